// File: rtl/cnn_dec_pkg.sv
// Shared definitions for the class score decider: FSM state encoding and
// the saturating adder used by every class accumulator.
package cnn_dec_pkg;

    // Legacy-compatible state codes, wrapped by the enum below.
    localparam logic [1:0] ST_ACCUM = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    typedef enum logic [1:0] {
        ACCUM = ST_ACCUM,
        SCAN  = ST_SCAN,
        HOLD  = ST_HOLD
    } dec_state_e;

    // Working width of the saturating adder; callers sign-extend into it.
    localparam int unsigned SAT_W = 64;

    // Adds two signed values and clamps the result to the signed range of w bits.
    function automatic logic signed [SAT_W-1:0] sat_add(
        input logic signed [SAT_W-1:0] a,
        input logic signed [SAT_W-1:0] b,
        input int unsigned             w
    );
        logic signed [SAT_W:0]   sum_s;
        logic signed [SAT_W:0]   hi_s;
        logic signed [SAT_W:0]   lo_s;
        logic signed [SAT_W-1:0] res_s;
        sum_s = {a[SAT_W-1], a} + {b[SAT_W-1], b};
        hi_s  = (65'sd1 <<< (w - 32'd1)) - 65'sd1;
        lo_s  = -hi_s - 65'sd1;
        if (sum_s > hi_s) begin
            res_s = hi_s[SAT_W-1:0];
        end else if (sum_s < lo_s) begin
            res_s = lo_s[SAT_W-1:0];
        end else begin
            res_s = sum_s[SAT_W-1:0];
        end
        return res_s;
    endfunction

endpackage

// File: rtl/class_score_accum.sv
// One class's score: reduces the COLS elements of an accepted beat and adds
// the result into a saturating signed accumulator.
module class_score_accum
    import cnn_dec_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int COLS       = 2,
    parameter int ACC_WIDTH  = 24
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         accept,
    input  logic signed [DATA_WIDTH-1:0] elems [COLS],
    output logic signed [ACC_WIDTH-1:0]  sum
);

    logic signed [SAT_W-1:0] beat_sum_s;
    logic signed [SAT_W-1:0] next_sum_s;

    // Exact beat reduction, then clamp the running score to ACC_WIDTH.
    always_comb begin
        beat_sum_s = {SAT_W{1'b0}};
        for (int c = 0; c < COLS; c++) begin
            beat_sum_s = beat_sum_s + SAT_W'(elems[c]);
        end
        next_sum_s = sat_add(SAT_W'(sum), beat_sum_s, ACC_WIDTH);
    end

    // Score register: cleared on reset or hand-off, updated on accepted beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum <= {ACC_WIDTH{1'b0}};
        end else if (clear) begin
            sum <= {ACC_WIDTH{1'b0}};
        end else if (accept) begin
            sum <= next_sum_s[ACC_WIDTH-1:0];
        end else begin
            sum <= sum;
        end
    end

endmodule

// File: rtl/class_score_decider.sv
// Class score decider: accumulates BEATS beats of per-class elements, then
// scans the classes one per cycle to find the winner and runner-up, and holds
// the result until downstream accepts it.
// Optional feature macro: CLASS_DEC_TOP2_EN (runner-up index and margin).
// Without it second_index and margin are constant 0; scan timing is identical.
// index/second_index are at least 1 bit wide so N_MATS=1 stays legal.
module class_score_decider
    import cnn_dec_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int N_MATS     = 10,
    parameter int COLS       = 2,
    parameter int BEATS      = 12,
    parameter int ACC_WIDTH  = 24,
    localparam int IDX_W     = (N_MATS > 1) ? $clog2(N_MATS) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid_in,
    output logic                         ready_in,
    input  logic signed [DATA_WIDTH-1:0] column [N_MATS][COLS],
    output logic signed [ACC_WIDTH-1:0]  max,
    output logic [IDX_W-1:0]             index,
    output logic [IDX_W-1:0]             second_index,
    output logic [ACC_WIDTH-1:0]         margin,
    output logic                         valid_out,
    input  logic                         ready_out
);

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    dec_state_e                  state_r;
    dec_state_e                  state_n;
    logic                        ready_in_r;
    logic [CNT_W-1:0]            beat_cnt_r;
    logic [IDX_W-1:0]            scan_idx_r;
    logic signed [ACC_WIDTH-1:0] sums_s [N_MATS];
    logic                        accept_s;
    logic                        clear_s;
    logic                        last_beat_s;
    logic                        last_scan_s;
    logic signed [ACC_WIDTH-1:0] cur_val_s;
    logic signed [ACC_WIDTH-1:0] best_val_r;
    logic [IDX_W-1:0]            best_idx_r;
    logic signed [ACC_WIDTH-1:0] nbest_val_s;
    logic [IDX_W-1:0]            nbest_idx_s;
    logic                        valid_out_r;
    logic signed [ACC_WIDTH-1:0] max_r;
    logic [IDX_W-1:0]            index_r;
`ifdef CLASS_DEC_TOP2_EN
    logic signed [ACC_WIDTH-1:0] sec_val_r;
    logic [IDX_W-1:0]            sec_idx_r;
    logic                        sec_ok_r;
    logic signed [ACC_WIDTH-1:0] nsec_val_s;
    logic [IDX_W-1:0]            nsec_idx_s;
    logic                        nsec_ok_s;
    logic [ACC_WIDTH:0]          diff_s;
    logic [IDX_W-1:0]            second_index_r;
    logic [ACC_WIDTH-1:0]        margin_r;
`endif

    assign accept_s    = valid_in && (state_r == ACCUM);
    assign clear_s     = (state_r == HOLD) && ready_out;
    assign last_beat_s = (beat_cnt_r == CNT_W'(BEATS - 1));
    assign last_scan_s = (scan_idx_r == IDX_W'(N_MATS - 1));

    for (genvar k = 0; k < N_MATS; k++) begin : g_class
        class_score_accum #(
            .DATA_WIDTH (DATA_WIDTH),
            .COLS       (COLS),
            .ACC_WIDTH  (ACC_WIDTH)
        ) u_accum (
            .clk    (clk),
            .rst    (rst),
            .clear  (clear_s),
            .accept (accept_s),
            .elems  (column[k]),
            .sum    (sums_s[k])
        );
    end

    // Next-state decode for the ACCUM -> SCAN -> HOLD -> ACCUM cycle.
    always_comb begin
        state_n = state_r;
        case (state_r)
            ACCUM: begin
                if (accept_s && last_beat_s) state_n = SCAN;
                else                         state_n = ACCUM;
            end
            SCAN: begin
                if (last_scan_s) state_n = HOLD;
                else             state_n = SCAN;
            end
            HOLD: begin
                if (ready_out) state_n = ACCUM;
                else           state_n = HOLD;
            end
            default: state_n = ACCUM;
        endcase
    end

    // One scan step: strict greater-than keeps the lowest index on ties and
    // lets an equal later class take the runner-up slot.
    always_comb begin
        cur_val_s = {ACC_WIDTH{1'b0}};
        for (int k = 0; k < N_MATS; k++) begin
            if (scan_idx_r == IDX_W'(k)) cur_val_s = sums_s[k];
            else                         cur_val_s = cur_val_s;
        end
        nbest_val_s = best_val_r;
        nbest_idx_s = best_idx_r;
`ifdef CLASS_DEC_TOP2_EN
        nsec_val_s = sec_val_r;
        nsec_idx_s = sec_idx_r;
        nsec_ok_s  = sec_ok_r;
`endif
        if (scan_idx_r == {IDX_W{1'b0}}) begin
            nbest_val_s = cur_val_s;
            nbest_idx_s = scan_idx_r;
`ifdef CLASS_DEC_TOP2_EN
            nsec_val_s = {ACC_WIDTH{1'b0}};
            nsec_idx_s = {IDX_W{1'b0}};
            nsec_ok_s  = 1'b0;
`endif
        end else if (cur_val_s > best_val_r) begin
`ifdef CLASS_DEC_TOP2_EN
            nsec_val_s = best_val_r;
            nsec_idx_s = best_idx_r;
            nsec_ok_s  = 1'b1;
`endif
            nbest_val_s = cur_val_s;
            nbest_idx_s = scan_idx_r;
`ifdef CLASS_DEC_TOP2_EN
        end else if (!sec_ok_r || (cur_val_s > sec_val_r)) begin
            nsec_val_s = cur_val_s;
            nsec_idx_s = scan_idx_r;
            nsec_ok_s  = 1'b1;
`endif
        end else begin
            nbest_val_s = best_val_r;
        end
`ifdef CLASS_DEC_TOP2_EN
        if (nsec_ok_s) diff_s = {nbest_val_s[ACC_WIDTH-1], nbest_val_s} - {nsec_val_s[ACC_WIDTH-1], nsec_val_s};
        else           diff_s = {(ACC_WIDTH + 1){1'b0}};
`endif
    end

    // FSM state, handshake flag, beat counter and scan pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ACCUM;
            ready_in_r <= 1'b1;
            beat_cnt_r <= {CNT_W{1'b0}};
            scan_idx_r <= {IDX_W{1'b0}};
        end else begin
            state_r    <= state_n;
            ready_in_r <= (state_n == ACCUM);
            if (accept_s) beat_cnt_r <= last_beat_s ? {CNT_W{1'b0}} : beat_cnt_r + CNT_W'(1'b1);
            if (state_r == SCAN) scan_idx_r <= last_scan_s ? {IDX_W{1'b0}} : scan_idx_r + IDX_W'(1'b1);
        end
    end

    // Running best / runner-up trackers, advanced once per scan cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            best_val_r <= {ACC_WIDTH{1'b0}};
            best_idx_r <= {IDX_W{1'b0}};
`ifdef CLASS_DEC_TOP2_EN
            sec_val_r  <= {ACC_WIDTH{1'b0}};
            sec_idx_r  <= {IDX_W{1'b0}};
            sec_ok_r   <= 1'b0;
`endif
        end else if (state_r == SCAN) begin
            best_val_r <= nbest_val_s;
            best_idx_r <= nbest_idx_s;
`ifdef CLASS_DEC_TOP2_EN
            sec_val_r  <= nsec_val_s;
            sec_idx_r  <= nsec_idx_s;
            sec_ok_r   <= nsec_ok_s;
`endif
        end
    end

    // Result registers: loaded on the final scan step, held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out_r    <= 1'b0;
            max_r          <= {ACC_WIDTH{1'b0}};
            index_r        <= {IDX_W{1'b0}};
`ifdef CLASS_DEC_TOP2_EN
            second_index_r <= {IDX_W{1'b0}};
            margin_r       <= {ACC_WIDTH{1'b0}};
`endif
        end else if ((state_r == SCAN) && last_scan_s) begin
            valid_out_r    <= 1'b1;
            max_r          <= nbest_val_s;
            index_r        <= nbest_idx_s;
`ifdef CLASS_DEC_TOP2_EN
            second_index_r <= nsec_idx_s;
            margin_r       <= diff_s[ACC_WIDTH-1:0];
`endif
        end else if (clear_s) begin
            valid_out_r    <= 1'b0;
        end
    end

    assign ready_in  = ready_in_r;
    assign valid_out = valid_out_r;
    assign max       = max_r;
    assign index     = index_r;
`ifdef CLASS_DEC_TOP2_EN
    assign second_index = second_index_r;
    assign margin       = margin_r;
`else
    assign second_index = {IDX_W{1'b0}};
    assign margin       = {ACC_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_class_score_decider.sv
// Self-checking bench for class_score_decider: a frame-level reference model
// for the default instance, compared every cycle, plus directed scenarios and
// a second instance (ACC_WIDTH=16, N_MATS=1) for saturation and single class.
module tb_class_score_decider;

    localparam int NM = 10;
    localparam int NC = 2;
    localparam int NB = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // default instance
    logic               valid_in = 1'b0;
    logic               ready_in;
    logic signed [15:0] column [NM][NC];
    logic signed [23:0] max;
    logic [3:0]         index;
    logic [3:0]         second_index;
    logic [23:0]        margin;
    logic               valid_out;
    logic               ready_out = 1'b0;

    // saturation / single-class instance
    logic               valid_in_b = 1'b0;
    logic               ready_in_b;
    logic signed [15:0] column_b [1][NC];
    logic signed [15:0] max_b;
    logic [0:0]         index_b;
    logic [0:0]         second_index_b;
    logic [15:0]        margin_b;
    logic               valid_out_b;
    logic               ready_out_b = 1'b0;

    class_score_decider dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(ready_in), .column(column),
        .max(max), .index(index), .second_index(second_index), .margin(margin),
        .valid_out(valid_out), .ready_out(ready_out)
    );

    class_score_decider #(.DATA_WIDTH(16), .N_MATS(1), .COLS(2), .BEATS(12), .ACC_WIDTH(16)) dut_b (
        .clk(clk), .rst(rst), .valid_in(valid_in_b), .ready_in(ready_in_b), .column(column_b),
        .max(max_b), .index(index_b), .second_index(second_index_b), .margin(margin_b),
        .valid_out(valid_out_b), .ready_out(ready_out_b)
    );

    int errors = 0;
    int checks = 0;
    bit done   = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (default instance) ----------------
    longint m_sum [NM];
    int     m_cnt   = 0;
    int     m_wait  = 0;
    bit     m_valid = 1'b0;
    longint e_max = 0, e_margin = 0;
    int     e_idx = 0, e_sec = 0;

    function automatic longint clamp24(input longint v);
        if (v > 64'sd8388607)  return 64'sd8388607;
        if (v < -64'sd8388608) return -64'sd8388608;
        return v;
    endfunction

    task automatic decide();
        int best;
        int sec;
        best = 0;
        for (int k = 1; k < NM; k++) if (m_sum[k] > m_sum[best]) best = k;
        sec = -1;
        for (int k = 0; k < NM; k++)
            if (k != best && (sec < 0 || m_sum[k] > m_sum[sec])) sec = k;
        e_max = m_sum[best];
        e_idx = best;
`ifdef CLASS_DEC_TOP2_EN
        e_sec    = sec;
        e_margin = m_sum[best] - m_sum[sec];
`else
        e_sec    = 0;
        e_margin = 0;
`endif
    endtask

    task automatic model_step();
        longint s;
        if (rst) begin
            for (int k = 0; k < NM; k++) m_sum[k] = 0;
            m_cnt = 0; m_wait = 0; m_valid = 1'b0;
            e_max = 0; e_idx = 0; e_sec = 0; e_margin = 0;
        end else if (m_valid) begin
            if (ready_out) begin
                m_valid = 1'b0;
                for (int k = 0; k < NM; k++) m_sum[k] = 0;
            end
        end else if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) begin
                decide();
                m_valid = 1'b1;
            end
        end else if (valid_in) begin
            for (int k = 0; k < NM; k++) begin
                s = 0;
                for (int c = 0; c < NC; c++) s += longint'(column[k][c]);
                m_sum[k] = clamp24(m_sum[k] + s);
            end
            m_cnt++;
            if (m_cnt == NB) begin
                m_cnt  = 0;
                m_wait = NM;  // result appears NM clock edges after the last accepted beat
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Compare process: every cycle, default instance against the model.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (!done) begin
                check("ready_in", ready_in, (!m_valid && m_wait == 0));
                check("valid_out", valid_out, m_valid);
                check("max", longint'(max), e_max);
                check("index", index, e_idx);
                check("second_index", second_index, e_sec);
                check("margin", longint'(margin), e_margin);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic zero_cols();
        for (int k = 0; k < NM; k++) for (int c = 0; c < NC; c++) column[k][c] = 16'sd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame_hot7();
        for (int b = 0; b < NB; b++) begin
            zero_cols();
            column[7][0] = 16'sd1;
            column[7][1] = 16'sd1;
            valid_in = 1'b1;
            tick();
        end
        valid_in = 1'b0;
        zero_cols();
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!valid_out && lat < 200) begin
            tick();
            lat++;
        end
        if (!valid_out) check("valid_timeout", 0, 1);
    endtask

    task automatic release_main();
        ready_out = 1'b1;
        tick();
        ready_out = 1'b0;
    endtask

    task automatic frame_b(input logic signed [15:0] v);
        int lat;
        for (int b = 0; b < NB; b++) begin
            column_b[0][0] = v;
            column_b[0][1] = v;
            valid_in_b = 1'b1;
            tick();
        end
        valid_in_b = 1'b0;
        lat = 0;
        while (!valid_out_b && lat < 200) begin
            tick();
            lat++;
        end
        check("b_latency", lat, 1);
    endtask

    function automatic logic signed [15:0] rand_elem();
        int v;
        if ($urandom_range(0, 3) == 0) return 16'($urandom);
        v = int'($urandom_range(0, 6)) - 3;
        return 16'(v);
    endfunction

    // ---------------- directed + random sequence ----------------
    initial begin
        int lat;
        zero_cols();
        column_b[0][0] = 16'sd0;
        column_b[0][1] = 16'sd0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;

        // reset state
        check("rst_ready_in", ready_in, 1);
        check("rst_valid_out", valid_out, 0);
        check("rst_max", longint'(max), 0);
        check("rst_index", index, 0);
        check("rst_ready_in_b", ready_in_b, 1);

        // one-hot class 7
        frame_hot7();
        wait_valid(lat);
        check("t1_latency", lat, NM);
        check("t1_index", index, 7);
        check("t1_max", longint'(max), 24);
        check("t1_second", second_index, 0);
`ifdef CLASS_DEC_TOP2_EN
        check("t1_margin", longint'(margin), 24);
`else
        check("t1_margin", longint'(margin), 0);
`endif
        release_main();

        // tie between classes 3 and 5 at 100
        for (int b = 0; b < NB; b++) begin
            zero_cols();
            if (b == 0)  column[3][0] = 16'sd100;
            if (b == 5)  column[5][0] = 16'sd40;
            if (b == 11) column[5][1] = 16'sd60;
            if (b == 2)  column[1][0] = 16'sd99;
            column[9][1] = -16'sd1;
            valid_in = 1'b1;
            tick();
        end
        valid_in = 1'b0;
        zero_cols();
        wait_valid(lat);
        check("t2_index", index, 3);
`ifdef CLASS_DEC_TOP2_EN
        check("t2_second", second_index, 5);
`else
        check("t2_second", second_index, 0);
`endif
        check("t2_margin", longint'(margin), 0);
        release_main();

        // backpressure with ignored beats
        frame_hot7();
        wait_valid(lat);
        for (int i = 0; i < 20; i++) begin
            valid_in = 1'b1;
            for (int k = 0; k < NM; k++) for (int c = 0; c < NC; c++) column[k][c] = rand_elem();
            tick();
            check("t4_ready_in", ready_in, 0);
            check("t4_valid", valid_out, 1);
            check("t4_max", longint'(max), 24);
            check("t4_index", index, 7);
        end
        valid_in = 1'b0;
        zero_cols();
        release_main();
        check("t4_cleared_valid", valid_out, 0);
        check("t4_hold_max", longint'(max), 24);
        frame_hot7();
        wait_valid(lat);
        check("t4_next_max", longint'(max), 24);
        check("t4_next_index", index, 7);
        release_main();

        // reset mid-frame
        for (int b = 0; b < 6; b++) begin
            zero_cols();
            column[2][0] = 16'sd500;
            column[2][1] = 16'sd500;
            valid_in = 1'b1;
            tick();
        end
        valid_in = 1'b0;
        zero_cols();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        frame_hot7();
        wait_valid(lat);
        check("t5_index", index, 7);
        check("t5_max", longint'(max), 24);
        release_main();

        // saturation on the 16-bit single-class instance
        frame_b(16'sh7FFF);
        check("t3_pos_max", longint'(max_b), 32767);
        check("t3_pos_index", index_b, 0);
        check("t3_pos_second", second_index_b, 0);
        check("t3_pos_margin", longint'(margin_b), 0);
        ready_out_b = 1'b1;
        tick();
        ready_out_b = 1'b0;
        frame_b(16'sh8000);
        check("t3_neg_max", longint'(max_b), -32768);
        check("t3_neg_margin", longint'(margin_b), 0);
        ready_out_b = 1'b1;
        tick();
        ready_out_b = 1'b0;

        // randomized traffic with spurious beats, backpressure and resets
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst       = ($urandom_range(0, 499) == 0);
            valid_in  = ($urandom_range(0, 9) < 7);
            ready_out = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < NM; k++) for (int c = 0; c < NC; c++) column[k][c] = rand_elem();
            tick();
        end
        rst = 1'b0;
        valid_in = 1'b0;
        ready_out = 1'b1;
        tick(); tick();

        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
